// File: rtl/banked_data_ram.sv
// Byte-lane-banked synchronous data RAM for the MEM stage.
// Registered request/ready handshake, configurable wait states, address-range error.
package banked_data_ram_pkg;
   typedef enum logic {CHIP_DISABLE = 1'b0, CHIP_ENABLE = 1'b1} chip_status_t;
endpackage

module banked_data_ram
   import banked_data_ram_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_WORDS = 131072,
   parameter int WAIT_STATES = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  chip_status_t            ce,
   input  logic                    we,
   input  logic [DATA_WIDTH/8-1:0] sel,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   data_i,
   output logic [DATA_WIDTH-1:0]   data_o,
   output logic                    ready,
   output logic                    err,
   output logic                    busy
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFF   = $clog2(BYTES);
   localparam int IDXW  = $clog2(DEPTH_WORDS);
   localparam int TOP   = OFF + IDXW;

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   state_t                  state_r;
   logic [3:0]              cnt_r;
   logic                    we_r;
   logic                    oor_r;
   logic                    ready_r;
   logic                    err_r;
   logic                    busy_r;
   logic                    use_rd_r;
   logic [DATA_WIDTH-1:0]   hold_r;
   logic [DATA_WIDTH-1:0]   rd_word_s;
   logic                    accept_s;
   logic                    oor_s;
   logic [IDXW-1:0]         idx_s;

   assign accept_s = (state_r == IDLE) && (ce == CHIP_ENABLE);
   assign idx_s    = addr[TOP-1:OFF];

   generate
      if (ADDR_WIDTH > TOP) begin : g_range
         assign oor_s = |addr[ADDR_WIDTH-1:TOP];
      end else begin : g_norange
         assign oor_s = 1'b0;
      end
   endgenerate

   for (genvar i = 0; i < BYTES; i++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_byte_r;

      // Lane storage: byte write or whole-word read capture at the acceptance edge
      always_ff @(posedge clk) begin
         if (rst_n && accept_s && !oor_s) begin
            if (we) begin
               if (sel[i]) begin
                  mem[idx_s] <= data_i[8*i +: 8];
               end
            end else begin
               rd_byte_r <= mem[idx_s];
            end
         end
      end

      assign rd_word_s[8*i +: 8] = rd_byte_r;
   end

   // The read register is reloaded at acceptance, so data_o shows it only once
   // the read has completed; otherwise the held copy keeps the last result.
   assign data_o = use_rd_r ? rd_word_s : hold_r;
   assign ready  = ready_r;
   assign err    = err_r;
   assign busy   = busy_r;

   // Request FSM with registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         cnt_r    <= 4'd0;
         we_r     <= 1'b0;
         oor_r    <= 1'b0;
         ready_r  <= 1'b0;
         err_r    <= 1'b0;
         busy_r   <= 1'b0;
         use_rd_r <= 1'b0;
         hold_r   <= {DATA_WIDTH{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               ready_r <= 1'b0;
               err_r   <= 1'b0;
               if (accept_s) begin
                  we_r     <= we;
                  oor_r    <= oor_s;
                  hold_r   <= data_o;
                  use_rd_r <= 1'b0;
                  busy_r   <= 1'b1;
                  if (WAIT_STATES > 0) begin
                     state_r <= WAIT;
                     cnt_r   <= 4'(WAIT_STATES - 1);
                  end else begin
                     state_r <= RESP;
                     ready_r <= 1'b1;
                     err_r   <= oor_s;
                     if (oor_s) begin
                        hold_r <= {DATA_WIDTH{1'b0}};
                     end else if (!we) begin
                        use_rd_r <= 1'b1;
                     end else begin
                        use_rd_r <= 1'b0;
                     end
                  end
               end else begin
                  busy_r <= 1'b0;
               end
            end
            WAIT: begin
               if (cnt_r == 4'd0) begin
                  state_r <= RESP;
                  ready_r <= 1'b1;
                  err_r   <= oor_r;
                  if (oor_r) begin
                     hold_r   <= {DATA_WIDTH{1'b0}};
                     use_rd_r <= 1'b0;
                  end else if (!we_r) begin
                     use_rd_r <= 1'b1;
                  end else begin
                     use_rd_r <= 1'b0;
                  end
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            RESP: begin
               state_r <= IDLE;
               ready_r <= 1'b0;
               err_r   <= 1'b0;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               ready_r <= 1'b0;
               err_r   <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_banked_data_ram.sv
// Self-checking bench: three instances (WAIT_STATES 1, 0, 3; DEPTH_WORDS 1024)
// checked against a word-array reference model with directed and random requests.
module tb_banked_data_ram;
   import banked_data_ram_pkg::*;

   localparam int DEPTH = 1024;
   localparam int NU    = 3;

   logic         clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n_v [NU];
   chip_status_t ce_v    [NU];
   logic         we_v    [NU];
   logic [3:0]   sel_v   [NU];
   logic [31:0]  addr_v  [NU];
   logic [31:0]  din_v   [NU];
   logic [31:0]  dout_v  [NU];
   logic         ready_v [NU];
   logic         err_v   [NU];
   logic         busy_v  [NU];

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [31:0] model_mem  [NU][DEPTH];
   logic [31:0] model_dout [NU];

   banked_data_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u0 (
      .clk(clk), .rst_n(rst_n_v[0]), .ce(ce_v[0]), .we(we_v[0]), .sel(sel_v[0]), .addr(addr_v[0]),
      .data_i(din_v[0]), .data_o(dout_v[0]), .ready(ready_v[0]), .err(err_v[0]), .busy(busy_v[0]));
   banked_data_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u1 (
      .clk(clk), .rst_n(rst_n_v[1]), .ce(ce_v[1]), .we(we_v[1]), .sel(sel_v[1]), .addr(addr_v[1]),
      .data_i(din_v[1]), .data_o(dout_v[1]), .ready(ready_v[1]), .err(err_v[1]), .busy(busy_v[1]));
   banked_data_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u2 (
      .clk(clk), .rst_n(rst_n_v[2]), .ce(ce_v[2]), .we(we_v[2]), .sel(sel_v[2]), .addr(addr_v[2]),
      .data_i(din_v[2]), .data_o(dout_v[2]), .ready(ready_v[2]), .err(err_v[2]), .busy(busy_v[2]));

   function automatic int ws_of(input int u);
      case (u)
         0:       return 1;
         1:       return 0;
         default: return 3;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // One complete request: model update, drive, wait for ready, check response
   task automatic do_req(input int u, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d, output logic [31:0] got);
      logic        exp_err;
      int          idx;
      int          lat;
      bit          done;
      logic [31:0] word;
      exp_err = (a[31:12] != 20'd0);
      idx     = int'(a[11:2]);
      if (exp_err) begin
         model_dout[u] = 32'd0;
      end else if (w) begin
         word = model_mem[u][idx];
         for (int b = 0; b < 4; b++) if (s[b]) word[8*b +: 8] = d[8*b +: 8];
         model_mem[u][idx] = word;
      end else begin
         model_dout[u] = model_mem[u][idx];
      end
      @(negedge clk);
      ce_v[u] = CHIP_ENABLE; we_v[u] = w; sel_v[u] = s; addr_v[u] = a; din_v[u] = d;
      lat = 0; done = 0;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (ready_v[u]) done = 1;
         else chk("busy_wait", {31'd0, busy_v[u]}, 32'd1);
      end
      ce_v[u] = CHIP_DISABLE;
      got = dout_v[u];
      if (!done) chk("timeout", 32'd0, 32'd1);
      else chk("latency", lat, ws_of(u) + 1);
      chk("err", {31'd0, err_v[u]}, {31'd0, exp_err});
      chk("data_o", dout_v[u], model_dout[u]);
      @(posedge clk); #1;
      chk("ready_pulse", {31'd0, ready_v[u]}, 32'd0);
      chk("busy_idle", {31'd0, busy_v[u]}, 32'd0);
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] a;
      int          nrdy;
      int          prev;
      for (int u = 0; u < NU; u++) begin
         rst_n_v[u] = 1'b0; ce_v[u] = CHIP_DISABLE; we_v[u] = 1'b0; sel_v[u] = 4'd0;
         addr_v[u] = 32'd0; din_v[u] = 32'd0; model_dout[u] = 32'd0;
      end
      repeat (2) @(negedge clk);
      for (int u = 0; u < NU; u++) begin
         chk("rst_ready", {31'd0, ready_v[u]}, 32'd0);
         chk("rst_err", {31'd0, err_v[u]}, 32'd0);
         chk("rst_busy", {31'd0, busy_v[u]}, 32'd0);
         chk("rst_data", dout_v[u], 32'd0);
         rst_n_v[u] = 1'b1;
      end

      // Directed: full write/read, byte lanes, range error, sel=0 unaligned (WS=1)
      do_req(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, got);
      do_req(0, 1'b0, 4'h0, 32'h10, 32'h0, got);
      chk("dir_full", got, 32'hDEADBEEF);
      do_req(0, 1'b1, 4'hF, 32'h20, 32'h11223344, got);
      do_req(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, got);
      do_req(0, 1'b0, 4'hF, 32'h20, 32'h0, got);
      chk("dir_lanes", got, 32'h11BB33DD);
      do_req(0, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D, got);
      do_req(0, 1'b0, 4'hF, 32'h1000, 32'h0, got);
      chk("dir_oor_data", got, 32'h0);
      do_req(0, 1'b1, 4'hF, 32'h1000, 32'h55555555, got);
      do_req(0, 1'b0, 4'hF, 32'h0, 32'h0, got);
      chk("dir_oor_nowrite", got, 32'hCAFEF00D);
      do_req(0, 1'b1, 4'hF, 32'h40, 32'h0BADC0DE, got);
      do_req(0, 1'b1, 4'h0, 32'h43, 32'hFFFFFFFF, got);
      do_req(0, 1'b0, 4'h0, 32'h43, 32'h0, got);
      chk("dir_sel0", got, 32'h0BADC0DE);

      // Held ce at WS=0: one ready every second cycle
      do_req(1, 1'b1, 4'hF, 32'h10, 32'h600DF00D, got);
      @(negedge clk);
      ce_v[1] = CHIP_ENABLE; we_v[1] = 1'b0; sel_v[1] = 4'hF; addr_v[1] = 32'h10;
      nrdy = 0; prev = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         chk("held_pattern", {31'd0, ready_v[1]}, (c % 2 == 0) ? 32'd1 : 32'd0);
         if (ready_v[1]) begin
            nrdy++;
            chk("held_data", dout_v[1], 32'h600DF00D);
         end
      end
      ce_v[1] = CHIP_DISABLE;
      chk("held_count", nrdy, 3);
      model_dout[1] = 32'h600DF00D;
      repeat (2) @(posedge clk);

      // Reset during WAIT at WS=3: write stays, response dropped
      @(negedge clk);
      ce_v[2] = CHIP_ENABLE; we_v[2] = 1'b1; sel_v[2] = 4'hF; addr_v[2] = 32'h40; din_v[2] = 32'h12345678;
      @(posedge clk); #1;
      chk("mid_busy", {31'd0, busy_v[2]}, 32'd1);
      @(posedge clk); #1;
      rst_n_v[2] = 1'b0;
      ce_v[2] = CHIP_DISABLE;
      #1;
      chk("mid_rst_busy", {31'd0, busy_v[2]}, 32'd0);
      chk("mid_rst_ready", {31'd0, ready_v[2]}, 32'd0);
      chk("mid_rst_err", {31'd0, err_v[2]}, 32'd0);
      model_mem[2][16] = 32'h12345678;
      model_dout[2] = 32'd0;
      nrdy = 0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (ready_v[2]) nrdy++;
      end
      @(negedge clk);
      rst_n_v[2] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (ready_v[2]) nrdy++;
      end
      chk("mid_no_ready", nrdy, 0);
      do_req(2, 1'b0, 4'hF, 32'h40, 32'h0, got);
      chk("mid_committed", got, 32'h12345678);

      // Random traffic on every instance against the model
      for (int u = 0; u < NU; u++) begin
         for (int k = 0; k < 16; k++) do_req(u, 1'b1, 4'hF, 32'(k << 2), $urandom(), got);
         for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom() | 32'h1000;
            else a = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
            do_req(u, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom(), got);
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
